// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the LC-3b memory-port arbiter.
//   lc3b_word       byte address (16 bits)
//   lc3b_line       one pmem transfer / cache line (128 bits)
//   lc3b_arb_state  arbiter FSM state
package mem_arbiter_pkg;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the I and D requesters.
//   i_req         in   I requester active
//   d_req         in   D requester active (read or write)
//   last_grant_d  in   previous grant went to D (only with MEM_ARB_RR_EN)
//   pick_d        out  1 = D wins, 0 = I wins (meaningful only if a request is active)
// Build option MEM_ARB_RR_EN: ties alternate based on last_grant_d;
// otherwise D always wins a tie.
module mem_arb_pick (
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant_d,
`endif
  output logic pick_d
);

  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      // Give the tie to whoever did not win last time.
      pick_d = !last_grant_d;
`else
      pick_d = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single pmem port between the LC-3b I-cache and
// D-cache miss interfaces. One requester is served at a time; after every
// transaction the port is released for one cycle so a still-held request
// is not immediately regranted.
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_read, i_address               I read request (level, held until i_resp)
//   i_rdata, i_resp                 I read data / one-cycle completion
//   d_read, d_write, d_address,
//   d_wdata                         D request (level, held until d_resp)
//   d_rdata, d_resp                 D read data / one-cycle completion
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata        registered memory request
//   pmem_rdata, pmem_resp           memory read data / completion
//   grant_d                         1 while D owns the port
// Build option MEM_ARB_RR_EN: round-robin tie-break (I wins the first tie);
// default build gives every tie to D.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = LC3B_ADDR_W,
  parameter int LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              grant_d
);

  lc3b_arb_state state;
  logic          d_req;
  logic          pick_d;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  logic last_grant_d;

  mem_arb_pick u_pick (
    .i_req        (i_read),
    .d_req        (d_req),
    .last_grant_d (last_grant_d),
    .pick_d       (pick_d)
  );
`else
  mem_arb_pick u_pick (
    .i_req  (i_read),
    .d_req  (d_req),
    .pick_d (pick_d)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      grant_d      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_d <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_read || d_req) begin
            grant_d <= pick_d;
`ifdef MEM_ARB_RR_EN
            last_grant_d <= pick_d;
`endif
            if (pick_d) begin
              state        <= SERVE_D;
              pmem_address <= d_address;
              pmem_wdata   <= d_wdata;
              // A simultaneous read+write is illegal; the write takes it.
              pmem_write   <= d_write;
              pmem_read    <= !d_write;
            end else begin
              state        <= SERVE_I;
              pmem_address <= i_address;
              pmem_wdata   <= '0;
              pmem_write   <= 1'b0;
              pmem_read    <= 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          // Request levels are ignored here: a dropped request still completes.
          if (pmem_resp) begin
            state      <= RELEASE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            grant_d    <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is a same-cycle passthrough of pmem_resp to the owner only.
  assign i_resp  = (state == SERVE_I) && pmem_resp;
  assign d_resp  = (state == SERVE_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule
